// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mips_mem_pkg;

    localparam int WAIT_W = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Processor-side data-memory bus.
interface dmem_responder_if;

    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;

    modport master (
        output DataMem_Read,
        output DataMem_Write,
        output DataMem_Address,
        output DataMem_Out,
        input  DataMem_In,
        input  DataMem_Ready
    );

    modport slave (
        input  DataMem_Read,
        input  DataMem_Write,
        input  DataMem_Address,
        input  DataMem_Out,
        output DataMem_In,
        output DataMem_Ready
    );

endinterface

// File: rtl/dmem_word_ram.sv
// Word RAM: one byte-enabled synchronous write port, one registered read port.
module dmem_word_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clock,
    input  logic [3:0]               byte_en,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder; define DMEM_RANDOM_WAIT_EN
// for LFSR-driven wait counts instead of fixed WAIT_CYCLES.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic             ProtoErr
);

    localparam int AW = $clog2(DEPTH);

    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] wait_load;
    logic [AW-1:0]     addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        en_q;
    logic              is_wr;
    logic [31:0]       rd_hold;
    logic [AW-1:0]     raddr;
    logic [31:0]       ram_rdata;
    logic [3:0]        ram_we;
    logic              req;
    logic              unused_addr_hi;

    assign req = bus.DataMem_Read | (|bus.DataMem_Write);
    assign unused_addr_hi = ^bus.DataMem_Address;

`ifdef DMEM_RANDOM_WAIT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign wait_load = lfsr[WAIT_W-1:0];
`else
    assign wait_load = WAIT_W'(WAIT_CYCLES);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ProtoErr <= 1'b0;
            rd_hold  <= '0;
            is_wr    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            en_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= bus.DataMem_Address[AW-1:0];
                        wdata_q <= bus.DataMem_Out;
                        en_q    <= bus.DataMem_Write;
                        is_wr   <= |bus.DataMem_Write;
                        if (bus.DataMem_Read && (|bus.DataMem_Write)) begin
                            ProtoErr <= 1'b1;
                        end
                        if (wait_load == '0) begin
                            state <= RESP;
                        end else begin
                            cnt   <= wait_load;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        ProtoErr <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == WAIT_W'(1)) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (!is_wr) begin
                        rd_hold <= ram_rdata;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // In IDLE the RAM looks up the incoming address so a zero-wait read
    // has its data ready in the very next (RESP) cycle.
    assign raddr  = (state == IDLE) ? bus.DataMem_Address[AW-1:0] : addr_q;
    assign ram_we = (state == RESP && is_wr) ? en_q : 4'b0000;

    assign bus.DataMem_Ready = (state == RESP);
    assign bus.DataMem_In    = (state == RESP && !is_wr) ? ram_rdata : rd_hold;

    dmem_word_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .byte_en (ram_we),
        .waddr   (addr_q),
        .wdata   (wdata_q),
        .raddr   (raddr),
        .rdata   (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed + random bench for dmem_responder against a word-array model.
module tb_dmem_responder;

    logic clock = 1'b0;
    logic reset_a;
    logic reset_b;
    logic perr_a;
    logic perr_b;
    int   cyc = 0;
    int   n_asserts = 0;
    int   n_fail = 0;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_a (
        .clock    (clock),
        .reset    (reset_a),
        .bus      (bus_a),
        .ProtoErr (perr_a)
    );

    dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut_b (
        .clock    (clock),
        .reset    (reset_b),
        .bus      (bus_b),
        .ProtoErr (perr_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] mdl [2][64];
    logic [31:0] last [2];
    logic        perr [2];
    int          dep [2] = '{64, 16};
    int          wt [2] = '{2, 0};
    int          rdy_cyc [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int s, input logic rd, input logic [3:0] we,
                         input logic [29:0] addr, input logic [31:0] data);
        if (s == 1) begin
            bus_b.DataMem_Read = rd;
            bus_b.DataMem_Write = we;
            bus_b.DataMem_Address = addr;
            bus_b.DataMem_Out = data;
        end else begin
            bus_a.DataMem_Read = rd;
            bus_a.DataMem_Write = we;
            bus_a.DataMem_Address = addr;
            bus_a.DataMem_Out = data;
        end
    endtask

    function automatic logic get_ready(input int s);
        return (s == 1) ? bus_b.DataMem_Ready : bus_a.DataMem_Ready;
    endfunction

    function automatic logic [31:0] get_in(input int s);
        return (s == 1) ? bus_b.DataMem_In : bus_a.DataMem_In;
    endfunction

    function automatic logic get_perr(input int s);
        return (s == 1) ? perr_b : perr_a;
    endfunction

    // One complete transaction, model updated from the behavioural rules.
    task automatic op(input int s, input logic rd, input logic [3:0] we,
                      input logic [29:0] addr, input logic [31:0] data, input string tag);
        int idx;
        int n;
        idx = int'(addr) % dep[s];
        if (we != 4'b0) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mdl[s][idx][8*b +: 8] = data[8*b +: 8];
            end
            if (rd) perr[s] = 1'b1;
        end else begin
            last[s] = mdl[s][idx];
        end
        drive(s, rd, we, addr, data);
        n = 0;
        do begin
            tick();
            n++;
        end while (!get_ready(s) && n < 40);
`ifdef DMEM_RANDOM_WAIT_EN
        chk({tag, ":lat"}, 32'(n >= 1 && n <= 16), 32'd1);
`else
        chk({tag, ":lat"}, 32'(n), 32'(1 + wt[s]));
`endif
        rdy_cyc[s] = cyc;
        chk({tag, ":data"}, get_in(s), last[s]);
        chk({tag, ":perr"}, 32'(get_perr(s)), 32'(perr[s]));
        drive(s, 1'b0, 4'b0, 30'b0, 32'b0);
        tick();
        chk({tag, ":pulse"}, 32'(get_ready(s)), 32'd0);
        chk({tag, ":hold"}, get_in(s), last[s]);
        tick();
    endtask

    task automatic rst(input int s);
        drive(s, 1'b0, 4'b0, 30'b0, 32'b0);
        if (s == 1) reset_b = 1'b1; else reset_a = 1'b1;
        tick();
        tick();
        if (s == 1) reset_b = 1'b0; else reset_a = 1'b0;
        perr[s] = 1'b0;
        last[s] = 32'h0;
        chk("rst:ready", 32'(get_ready(s)), 32'd0);
        chk("rst:in", get_in(s), 32'h0);
        chk("rst:perr", 32'(get_perr(s)), 32'd0);
    endtask

    initial begin
        logic [29:0] a;
        logic [3:0]  e;
        int          k;
        int          r1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        drive(0, 1'b0, 4'b0, 30'b0, 32'b0);
        drive(1, 1'b0, 4'b0, 30'b0, 32'b0);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 64; i++) mdl[s][i] = 32'h0;
        end
        rst(0);
        rst(1);

        op(0, 1'b0, 4'b1111, 30'd5, 32'hDEADBEEF, "w5");
        op(0, 1'b1, 4'b0000, 30'd5, 32'h0, "r5");
        op(0, 1'b0, 4'b0001, 30'd5, 32'h000000AA, "bw5");
        op(0, 1'b1, 4'b0000, 30'd5, 32'h0, "r5b");
        chk("r5b:value", bus_a.DataMem_In, 32'hDEADBEAA);

`ifndef DMEM_RANDOM_WAIT_EN
        drive(0, 1'b1, 4'b0, 30'd5, 32'h0);
        tick();
        tick();
        drive(0, 1'b0, 4'b0, 30'b0, 32'b0);
        tick();
        perr[0] = 1'b1;
        chk("abort:perr", 32'(perr_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("abort:ready", 32'(bus_a.DataMem_Ready), 32'd0);
            chk("abort:in", bus_a.DataMem_In, last[0]);
            tick();
        end
        chk("abort:sticky", 32'(perr_a), 32'd1);
        op(0, 1'b1, 4'b0000, 30'd5, 32'h0, "abort_r5");
`endif

        rst(0);
        op(0, 1'b1, 4'b0000, 30'd5, 32'h0, "keep_r5");
        op(0, 1'b1, 4'b1111, 30'd7, 32'h12345678, "rw7");
        op(0, 1'b1, 4'b0000, 30'd7, 32'h0, "r7");

`ifndef DMEM_RANDOM_WAIT_EN
        op(0, 1'b0, 4'b1111, 30'd9, 32'h0BADF00D, "w9");
        op(0, 1'b1, 4'b0000, 30'd9, 32'h0, "r9");
        drive(0, 1'b0, 4'b1111, 30'd9, 32'hFFFFFFFF);
        tick();
        tick();
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        drive(0, 1'b0, 4'b0, 30'b0, 32'b0);
        perr[0] = 1'b0;
        last[0] = 32'h0;
        chk("rstw:ready", 32'(bus_a.DataMem_Ready), 32'd0);
        chk("rstw:in", bus_a.DataMem_In, 32'h0);
        chk("rstw:perr", 32'(perr_a), 32'd0);
        tick();
        op(0, 1'b1, 4'b0000, 30'd9, 32'h0, "rstw_r9");
`endif

        for (int i = 0; i < 64; i++) begin
            a = 30'($urandom);
            a[5:0] = 6'(i);
            op(0, 1'b0, 4'b1111, a, $urandom, "init");
        end
        for (int i = 0; i < 100; i++) begin
            a = 30'($urandom);
            k = int'($urandom_range(0, 9));
            e = 4'($urandom_range(1, 15));
            if (k < 5) op(0, 1'b1, 4'b0000, a, $urandom, "rnd_rd");
            else if (k < 9) op(0, 1'b0, e, a, $urandom, "rnd_wr");
            else op(0, 1'b1, e, a, $urandom, "rnd_rw");
        end

        op(1, 1'b0, 4'b1111, 30'd1, 32'hCAFE0001, "b_w1");
        op(1, 1'b0, 4'b1111, 30'd2, 32'hCAFE0002, "b_w2");
        op(1, 1'b1, 4'b0000, 30'd1, 32'h0, "b_r1");
        r1 = rdy_cyc[1];
        op(1, 1'b1, 4'b0000, 30'd2, 32'h0, "b_r2");
`ifndef DMEM_RANDOM_WAIT_EN
        chk("b_gap", 32'(rdy_cyc[1] - r1), 32'd3);
`endif
        op(1, 1'b1, 4'b0000, 30'h3FFFFFF1, 32'h0, "b_alias");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter: DEPTH, 1024, number of 32-bit words stored (power of two, 16..65536).
REQ-002 SHALL have parameter: WAIT_CYCLES, 2, fixed wait states inserted before Ready (0..15).
REQ-003 SHALL have port: clock  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: DataMem_Read  input  1  read request from processor, held until Ready.
REQ-006 SHALL have port: DataMem_Write  input  4  per-byte write enables, bit 3 = bits 31:24, held until Ready.
REQ-007 SHALL have port: DataMem_Address  input  30  word address.
REQ-008 SHALL have port: DataMem_Out  input  32  write data from processor.
REQ-009 SHALL have port: DataMem_In  output  32  read data to processor.
REQ-010 SHALL have port: DataMem_Ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: ProtoErr  output  1  sticky protocol-violation flag.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP, DONE.
REQ-013 IDLE: request = Read or any Write bit; on request SHALL latch address (low log2(DEPTH) bits), write data, enables, and kind; go to RESP if wait count 0, else load counter and go to WAIT.
REQ-014 WAIT: SHALL decrement counter each cycle and go to RESP when it reaches 1.
REQ-015 RESP: SHALL assert DataMem_Ready for exactly this one cycle and go to DONE.
REQ-016 DONE: SHALL ignore all inputs for one cycle and return to IDLE (processor drops request after Ready).
REQ-017 Latency: request first seen in IDLE at cycle T SHALL give Ready at cycle T+1+wait.
REQ-018 Read: DataMem_In SHALL carry mem[latched addr] in the Ready cycle and hold it until the next completed read.
REQ-019 Write: only bytes with enable set SHALL be updated, committed in the Ready cycle; DataMem_In unchanged.
REQ-020 Addresses beyond DEPTH SHALL alias (upper bits ignored).
REQ-021 Read and any Write bit together in IDLE: write SHALL take priority, complete normally, and set ProtoErr.
REQ-022 Request deasserted in WAIT: SHALL abort to IDLE, no write, no Ready, set ProtoErr.
REQ-023 Address/data changes during WAIT SHALL be ignored (latched values used).
REQ-024 ProtoErr SHALL remain set until reset.

Reset
REQ-025 Reset SHALL force IDLE, DataMem_Ready=0, DataMem_In=32'h0, ProtoErr=0, counter=0, from any state including mid-WAIT (pending write discarded).
REQ-026 Reset SHALL NOT clear memory contents.

Configuration
REQ-027 With DMEM_RANDOM_WAIT_EN defined: wait count SHALL be bits 3:0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1; advances every clock) sampled on accept; WAIT_CYCLES ignored.
REQ-028 Without DMEM_RANDOM_WAIT_EN: wait count SHALL be WAIT_CYCLES; no LFSR logic present.

Structure
REQ-029 Package mips_mem_pkg SHALL hold the FSM state enum, 4-bit wait-count width constant, LFSR seed and tap constants.
REQ-030 Storage SHALL be sub-module dmem_word_ram (one synchronous write port with 4 byte enables, one read port); FSM/counter/LFSR stay in dmem_responder.

Verification
REQ-031 WAIT_CYCLES=2, write 32'hDEADBEEF enables 4'b1111 addr 5 -> Ready exactly 3 cycles after request seen, one cycle wide; then read addr 5 -> DataMem_In=32'hDEADBEEF with Ready.
REQ-032 Byte write 32'h000000AA enables 4'b0001 to addr 5 after REQ-031 -> read returns 32'hDEADBEAA.
REQ-033 WAIT_CYCLES=0, back-to-back reads addr 1,2 -> Ready at T+1, DONE gap of one cycle, second Ready 3 cycles after first.
REQ-034 Read with request dropped after 1 WAIT cycle -> no Ready, ProtoErr=1 and stays 1; subsequent read still completes.
REQ-035 Read+Write(4'b1111, 32'h12345678) together at addr 7 -> Ready, ProtoErr=1, mem[7]=32'h12345678, DataMem_In unchanged.
REQ-036 Reset during WAIT of write to addr 9 -> Ready 0, DataMem_In=0, state IDLE, mem[9] unchanged; with DMEM_RANDOM_WAIT_EN, 100 random reads each complete within 16 cycles.
